// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-channel stability counter,
// debounced level plus one-cycle press/release strobes.
// Optional long-press strobe is built when BTN_DEBOUNCE_LONG_PRESS_EN is defined;
// otherwise long_o is tied to 0 and the port list is unchanged.
module btn_debounce #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned LONG_CYCLES     = 125000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] btn_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal parameterisations at elaboration.
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be 1 or more");
    end
    if (LONG_CYCLES == 0) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must be 1 or more");
    end

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_q;
    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [CNT_W-1:0] cnt [N_BTN];

    // Two-flop synchroniser bringing the raw buttons into clk_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= btn_i;
            sync_q    <= sync_meta;
        end
    end

    // Stability counter per channel: accept a new level after an unbroken mismatch run.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                press_q[i]   <= 1'b0;
                release_q[i] <= 1'b0;
                if (sync_q[i] == btn_q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_q[i]     <= sync_q[i];
                    cnt[i]       <= '0;
                    press_q[i]   <= sync_q[i];
                    release_q[i] <= ~sync_q[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold [N_BTN];
    logic [N_BTN-1:0]  long_q;

    // Hold timer per channel: saturating, one strobe per press, cleared on release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            long_q <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                long_q[i] <= 1'b0;
                if (!btn_q[i]) begin
                    hold[i] <= '0;
                end else if (hold[i] != HOLD_MAX) begin
                    hold[i] <= hold[i] + HOLD_W'(1);
                    if (hold[i] == HOLD_LAST) begin
                        long_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign long_o = long_q;
`else
    assign long_o = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32, N_BTN=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_btn_debounce;

    localparam int unsigned N_BTN = 4;
    localparam int unsigned DEB   = 8;
    localparam int unsigned LONG  = 32;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    localparam logic LONG_ON = 1'b1;
`else
    localparam logic LONG_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_out;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] lng;

    int n_vec;
    int n_err;

    btn_debounce #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .btn_i    (btn),
        .btn_o    (btn_out),
        .press_o  (press),
        .release_o(rel),
        .long_o   (lng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N_BTN-1:0] obs, input logic [N_BTN-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all four outputs at once.
    task automatic check_all(input string tag, input logic [N_BTN-1:0] e_btn, input logic [N_BTN-1:0] e_press,
                             input logic [N_BTN-1:0] e_rel, input logic [N_BTN-1:0] e_long);
        check({tag, ".btn"},     btn_out, e_btn);
        check({tag, ".press"},   press,   e_press);
        check({tag, ".release"}, rel,     e_rel);
        check({tag, ".long"},    lng,     e_long);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        btn   = 4'hF;

        // Reset holds everything at 0 even with all buttons pressed.
        tick(1);
        check_all("rst_a", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(3);
        check_all("rst_b", 4'h0, 4'h0, 4'h0, 4'h0);

        // Release reset: press strobe on all channels exactly 10 edges later.
        rst = 1'b0;
        tick(9);
        check_all("rst_e9", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("rst_e10", 4'hF, 4'hF, 4'h0, 4'h0);
        tick(1);
        check_all("rst_e11", 4'hF, 4'h0, 4'h0, 4'h0);

        // Drop all buttons so later tests start from a clean zero.
        btn = 4'h0;
        tick(10);
        check_all("clr_e10", 4'h0, 4'h0, 4'hF, 4'h0);
        tick(1);
        check_all("clr_e11", 4'h0, 4'h0, 4'h0, 4'h0);

        // Clean press on ch0.
        btn = 4'h1;
        tick(9);
        check_all("p0_e9", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("p0_e10", 4'h1, 4'h1, 4'h0, 4'h0);
        tick(1);
        check_all("p0_e11", 4'h1, 4'h0, 4'h0, 4'h0);

        // Keep ch0 held: long strobe 32 edges after btn_o rose, once only.
        tick(30);
        check("long_t31", lng, 4'h0);
        tick(1);
        check("long_t32", lng, {3'b000, LONG_ON});
        tick(1);
        check("long_t33", lng, 4'h0);

        // Bounce on ch1 (5 high, 2 low, 3 high, low) while ch0 stays held.
        btn = 4'h3;
        tick(5);
        check_all("bnc_h5", 4'h1, 4'h0, 4'h0, 4'h0);
        btn = 4'h1;
        tick(2);
        check_all("bnc_l2", 4'h1, 4'h0, 4'h0, 4'h0);
        btn = 4'h3;
        tick(3);
        check_all("bnc_h3", 4'h1, 4'h0, 4'h0, 4'h0);
        btn = 4'h1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            check("bnc_tail_press", press, 4'h0);
            check("bnc_tail_rel", rel, 4'h0);
        end
        check_all("bnc_end", 4'h1, 4'h0, 4'h0, 4'h0);

        // ch0 held well past 100 cycles: no repeat of the long strobe.
        tick(40);
        check("long_norepeat", lng, 4'h0);

        // Accept ch2 alongside ch0, then drop both together.
        btn = 4'h5;
        tick(10);
        check_all("p2_e10", 4'h5, 4'h4, 4'h0, 4'h0);
        tick(1);
        btn = 4'h0;
        tick(9);
        check_all("r02_e9", 4'h5, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("r02_e10", 4'h0, 4'h0, 4'h5, 4'h0);
        tick(1);
        check_all("r02_e11", 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset in the middle of a ch3 count discards the progress.
        btn = 4'h8;
        tick(6);
        check_all("mid_e6", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        #1;
        check_all("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        rst = 1'b0;
        tick(9);
        check_all("mid_e9", 4'h0, 4'h0, 4'h0, 4'h0);
        tick(1);
        check_all("mid_e10", 4'h8, 4'h8, 4'h0, 4'h0);
        tick(1);
        check_all("mid_e11", 4'h8, 4'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions raw Zybo push-button inputs for the LED/counter logic directly downstream.
- Each channel is synchronised into clk_i, then debounced by a per-channel stability counter.
- Outputs are a clean level per button plus single-cycle press and release strobes. These drive the blinky-class counter controls (reset, enable, mode step).

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1250000, consecutive mismatch cycles required to accept a new level (10 ms at 125 MHz); legal range is 1 or more.
- LONG_CYCLES, 125000000, held-high cycles before the long-press strobe (1 s at 125 MHz); only used with LONG_PRESS_EN; must be 1 or more.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- btn_i  input  N_BTN  raw button levels, asynchronous to clk_i, active-high.
- btn_o  output  N_BTN  debounced level per channel.
- press_o  output  N_BTN  one-cycle strobe on an accepted 0->1 transition.
- release_o  output  N_BTN  one-cycle strobe on an accepted 1->0 transition.
- long_o  output  N_BTN  one-cycle strobe when a press has been held for LONG_CYCLES.

Behaviour:
- Reset (async assert, sync-released by system):
  - Synchroniser flops, btn_o, press_o, release_o, long_o and all counters are 0.
  - Asserting rst_i mid-count discards all progress; no strobe is emitted.
- Synchroniser: two flops per channel, reset to 0. sync[i] is btn_i[i] delayed 2 edges.
- Per-channel counter cnt, width $clog2(DEBOUNCE_CYCLES+1), unsigned:
  - If sync == btn_o: cnt <= 0.
  - If sync != btn_o and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If sync != btn_o and cnt == DEBOUNCE_CYCLES-1: btn_o <= sync, cnt <= 0, and the matching strobe is asserted on the same edge.
- Acceptance rule: btn_o takes a new level only after DEBOUNCE_CYCLES consecutive cycles of sync differing from btn_o.
  - Latency from a clean btn_i step to btn_o change is exactly DEBOUNCE_CYCLES+2 clock edges.
- Glitches:
  - Any mismatch run shorter than DEBOUNCE_CYCLES resets cnt and produces no output change.
  - The count restarts from 0 on the next mismatch.
- Strobes:
  - press_o[i] and release_o[i] are registered and high for exactly the one cycle in which btn_o[i] first shows its new value.
  - press_o[i] and release_o[i] are never both high.
- Channels are fully independent; simultaneous transitions on several channels are each handled normally in the same cycle.
- No counter wraps; cnt never exceeds DEBOUNCE_CYCLES-1.
- DEBOUNCE_CYCLES=1: btn_o follows sync with one cycle of delay, i.e. a total latency of 3 edges.

Optional Feature:
- Macro: BTN_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_CYCLES+1), cleared while btn_o[i]==0.
  - While btn_o[i]==1 the counter increments and saturates at LONG_CYCLES.
  - long_o[i] pulses for one cycle on the edge where the counter becomes LONG_CYCLES. There is one pulse per press, with no repeat while held.
  - Release clears the counter; the next press re-arms the strobe.
  - Reset clears the counter and long_o.
- Undefined: the hold counters are not built; long_o is constant 0. The port list is identical in both builds.

Test Plan (bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=32, N_BTN=4):
- Reset: hold rst_i high with btn_i=4'hF -> btn_o, press_o, release_o and long_o all 0 throughout reset; after release, press_o[3:0]=4'hF pulses exactly 10 edges later.
- Clean press on ch0: btn_i[0] 0->1 at edge 0 -> btn_o[0]=1 and press_o[0]=1 at edge 10; press_o[0]=0 at edge 11; other channels remain 0.
- Bounce: btn_i[1] toggles high for 5 cycles, low for 2, high for 3, then low -> btn_o[1], press_o[1] and release_o[1] remain 0 throughout.
- Release plus simultaneous events: ch0 and ch2 held 1 and accepted; drop both at edge 0 -> release_o[0] and release_o[2] are both 1 at edge 10, each for one cycle.
- Reset mid-count: btn_i[3] goes high, rst_i pulses at edge 6 -> no press_o[3]; after rst_i falls, press_o[3] is accepted 10 edges later.
- With BTN_DEBOUNCE_LONG_PRESS_EN, hold ch0 for 100 cycles -> long_o[0] pulses exactly once, 32 cycles after btn_o[0] rises. Without the macro -> long_o stays 0.
